// File: rtl/hilo_muldiv_pkg.sv
// Shared constants, op codes and state encoding for the HI/LO multiply/divide sequencer.
package hilo_muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;
  localparam int CNT_W  = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_muldiv_step.sv
// One combinational shift-add multiply or restoring divide iteration on the 64-bit working register.
module muldiv_step
  import hilo_muldiv_pkg::*;
(
  input  logic                  div_mode,
  input  logic [2*DATA_W-1:0]   work,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   work_nxt
);

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] rem_diff;
  logic              rem_ge;

  always_comb begin
    mul_sum  = {1'b0, work[2*DATA_W-1:DATA_W]} + (work[0] ? {1'b0, opnd} : '0);
    // The shifted remainder can reach 33 bits before the trial subtract.
    rem_sh   = work[2*DATA_W-1:DATA_W-1];
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh[DATA_W-1:0] - opnd;
    if (div_mode) begin
      if (rem_ge) work_nxt = {rem_diff, work[DATA_W-2:0], 1'b1};
      else        work_nxt = {rem_sh[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
    end else begin
      work_nxt = {mul_sum, work[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO behind a valid/ready handshake.
// Build option HILO_FAST_MULT_EN: single-edge multiply through the synthesis multiplier.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_lo_q, neg_lo_d;
  logic                  neg_hi_q, neg_hi_d;
  logic [2*DATA_W-1:0]   work_q, work_d, step_out;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  done_q, done_d, div0_q, div0_d;

  logic signed [DATA_W-1:0] a_s, b_s;
  logic [DATA_W-1:0]        a_abs, b_abs;
  logic                     sgn_op;

  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  muldiv_step u_step (
    .div_mode (op_is_div(op_q)),
    .work     (work_q),
    .opnd     (opnd_q),
    .work_nxt (step_out)
  );

  always_comb begin
    sgn_op = op_is_signed(req_op);
    a_s    = req_a;
    b_s    = req_b;
    a_abs  = (sgn_op && a_s < 0) ? cond_neg32(req_a, 1'b1) : req_a;
    b_abs  = (sgn_op && b_s < 0) ? cond_neg32(req_b, 1'b1) : req_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          if (op_is_mul(req_op)) begin
            neg_lo_d = sgn_op && (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
            neg_hi_d = 1'b0;
`ifdef HILO_FAST_MULT_EN
            work_d  = {{DATA_W{1'b0}}, a_abs} * {{DATA_W{1'b0}}, b_abs};
            state_d = ST_FIX;
`else
            work_d  = {{DATA_W{1'b0}}, b_abs};
            opnd_d  = a_abs;
            cnt_d   = '0;
            state_d = ST_CALC;
`endif
          end else if (op_is_div(req_op)) begin
            if (req_b == '0) begin
              done_d = 1'b1;
              div0_d = 1'b1;
            end else begin
              neg_lo_d = sgn_op && (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
              neg_hi_d = sgn_op && req_a[DATA_W-1];
              work_d   = {{DATA_W{1'b0}}, a_abs};
              opnd_d   = b_abs;
              cnt_d    = '0;
              state_d  = ST_CALC;
            end
          end else if (req_op == OP_MTHI) begin
            hi_d   = req_a;
            done_d = 1'b1;
          end else if (req_op == OP_MTLO) begin
            lo_d   = req_a;
            done_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          work_d = step_out;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          if (op_is_mul(op_q)) begin
            {hi_d, lo_d} = cond_neg64(work_q, neg_lo_q);
          end else begin
            lo_d = cond_neg32(work_q[DATA_W-1:0], neg_lo_q);
            hi_d = cond_neg32(work_q[2*DATA_W-1:DATA_W], neg_hi_q);
          end
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      work_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign div0      = div0_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit; honours HILO_FAST_MULT_EN for multiply timing.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_mis = 0;
  int lat, bcnt;

`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 33;
`endif

  hilo_muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepts one request and returns edges from accept to the done cycle, and busy cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    l  = 0;
    bc = 0;
    while (!done && l < 200) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    chk("mult_lat", lat, MUL_LAT);
    chk("mult_busy", bcnt, MUL_BUSY);
    chk("mult_ready", req_ready, 1);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_lat", lat, MUL_LAT);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lat", lat, 33);
    chk("div_div0", div0, 0);

    run_op(3'd3, 32'd7, 32'd2, lat, bcnt);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'h0);
    chk("divmin_div0", div0, 0);

    run_op(3'd4, 32'h1234_5678, 32'd0, lat, bcnt);
    chk("mthi_lat", lat, 0);
    chk("mthi_hi", hi, 32'h1234_5678);

    run_op(3'd3, 32'd5, 32'd0, lat, bcnt);
    chk("div0_lat", lat, 0);
    chk("div0_flag", div0, 1);
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'h8000_0000);

    // Reserved op code: accepted, no done, no register change.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd6;
    req_a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("nop_done0", done, 0);
    @(posedge clk);
    #1;
    chk("nop_done1", done, 0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_ready", req_ready, 1);

    // Flush mid-divide while an MTLO waits for ready.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_a     = 32'd100;
    req_b     = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_a     = 32'hCAFE_BABE;
    chk("flush_busy_ready", req_ready, 0);
    chk("flush_busy", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h8000_0000);
    chk("flush_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mtlo_done", done, 1);
    chk("mtlo_lo", lo, 32'hCAFE_BABE);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'd5;
    req_b     = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifndef HILO_FAST_MULT_EN
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd2, 32'd3, lat, bcnt);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lat", lat, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
